cnc_lbus_readback: RTL and testbench

- Read-side responder on the 5i20 32-bit local bus for the CNC block; the companion to the existing write decoder.
- Latches the address on ADS, runs a read cycle with programmable wait states and a READY handshake, and drives LAD with the selected CNC status word.
- Also contains a signed step-position counter fed by the stepper clock/direction outputs, so the host can read back motor position and control state.

---
 rtl/cnc_lbus_pkg.sv | 40 ++++
 rtl/cnc_lbus_if.sv | 20 ++
 rtl/cnc_step_position.sv | 67 ++++++
 rtl/cnc_lbus_readback.sv | 149 ++++++++++++++
 tb/tb_cnc_lbus_readback.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnc_lbus_pkg.sv
// rtl/cnc_lbus_pkg.sv - shared CNC local-bus types, word indices and status bit layout
package cnc_lbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } lbus_state_t;

    localparam logic [2:0] W_ID   = 3'd0;
    localparam logic [2:0] W_RATE = 3'd1;
    localparam logic [2:0] W_STAT = 3'd2;
    localparam logic [2:0] W_POS  = 3'd3;
    localparam logic [2:0] W_OVF  = 3'd4;

    localparam int STAT_ST_CLK = 0;
    localparam int STAT_ST_ENB = 1;
    localparam int STAT_ST_DIS = 2;
    localparam int STAT_ST_DIR = 3;
    localparam int STAT_SP_BRK = 4;
    localparam int STAT_SP_DIS = 5;
    localparam int STAT_SP_DIR = 6;

    function automatic logic [31:0] pack_status(
        input logic st_clk, input logic st_enb, input logic st_dis, input logic st_dir,
        input logic sp_brk, input logic sp_dis, input logic sp_dir);
        logic [31:0] w;
        w = '0;
        w[STAT_ST_CLK] = st_clk;
        w[STAT_ST_ENB] = st_enb;
        w[STAT_ST_DIS] = st_dis;
        w[STAT_ST_DIR] = st_dir;
        w[STAT_SP_BRK] = sp_brk;
        w[STAT_SP_DIS] = sp_dis;
        w[STAT_SP_DIR] = sp_dir;
        return w;
    endfunction

endpackage

// File: rtl/cnc_lbus_if.sv
// rtl/cnc_lbus_if.sv - 5i20 local bus read-side signals with host (master) and responder (slave) views
interface cnc_lbus_if;
    logic        ADS_n;
    logic        LRD_n;
    logic        BLAST_n;
    logic [31:0] LAD_in;
    logic [31:0] LAD_out;
    logic        LAD_oe;
    logic        READY_n;

    modport slave (
        input  ADS_n, LRD_n, BLAST_n, LAD_in,
        output LAD_out, LAD_oe, READY_n
    );

    modport master (
        output ADS_n, LRD_n, BLAST_n, LAD_in,
        input  LAD_out, LAD_oe, READY_n
    );
endinterface

// File: rtl/cnc_step_position.sv
// rtl/cnc_step_position.sv - signed step position counter with overflow flag; CNC_POS_SNAPSHOT_EN adds a snapshot register
module cnc_step_position (
    input  logic        LClk,
    input  logic        rst,
    input  logic        i_st_clk,
    input  logic        i_st_enb,
    input  logic        i_st_dir,
    input  logic        i_pos_clr,
    input  logic        i_ovf_clr,
`ifdef CNC_POS_SNAPSHOT_EN
    input  logic        i_snap,
`endif
    output logic [31:0] o_pos_rd,
    output logic        o_ovf
);

    logic        r_st_clk_d;
    logic [31:0] r_pos;
    logic        r_ovf;
    logic        w_step;
    logic        w_wrap;
    logic [31:0] w_pos_nxt;

    // A clear in the same cycle suppresses the step, so it can never raise ovf.
    assign w_step    = i_st_clk && !r_st_clk_d && i_st_enb && !i_pos_clr;
    assign w_pos_nxt = i_st_dir ? (r_pos + 32'd1) : (r_pos - 32'd1);
    assign w_wrap    = i_st_dir ? (r_pos == 32'h7FFF_FFFF) : (r_pos == 32'h8000_0000);

    always_ff @(posedge LClk) begin
        if (!rst) begin
            r_st_clk_d <= 1'b0;
            r_pos      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_st_clk_d <= i_st_clk;
            if (i_pos_clr) begin
                r_pos <= '0;
            end else if (w_step) begin
                r_pos <= w_pos_nxt;
            end
            if (w_step && w_wrap) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_ovf = r_ovf;

`ifdef CNC_POS_SNAPSHOT_EN
    logic [31:0] r_snap;

    always_ff @(posedge LClk) begin
        if (!rst) begin
            r_snap <= '0;
        end else if (i_snap) begin
            r_snap <= r_pos;
        end
    end

    assign o_pos_rd = r_snap;
`else
    assign o_pos_rd = r_pos;
`endif

endmodule

// File: rtl/cnc_lbus_readback.sv
// rtl/cnc_lbus_readback.sv - CNC local-bus read responder: wait-state FSM, read mux, position counter; CNC_POS_SNAPSHOT_EN selects snapshot readback
module cnc_lbus_readback
    import cnc_lbus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_WORD     = 32'h5C1C_0001
) (
    input  logic        LClk,
    input  logic        rst,
    cnc_lbus_if.slave   bus,
    input  logic        st_clk,
    input  logic        st_dir,
    input  logic        st_enb,
    input  logic        st_dis,
    input  logic        sp_brk,
    input  logic        sp_dis,
    input  logic        sp_dir,
    input  logic [31:0] cnt_val,
    input  logic        pos_clr
);

    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    // WAIT lasts exactly WAIT_STATES cycles, so the counter is loaded one short.
    localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    lbus_state_t r_state;
    logic [2:0]  r_widx;
    logic [2:0]  r_wcnt;
    logic [31:0] r_lad;
    logic        r_oe;
    logic        r_ready_n;

    logic        w_enter_drive;
    logic [2:0]  w_rd_idx;
    logic [31:0] w_word;
    logic [31:0] w_pos_rd;
    logic        w_ovf;
    logic        w_ovf_clr;
    logic        w_unused_lad;

    assign w_unused_lad = ^{bus.LAD_in[31:5], bus.LAD_in[1:0]};

    // Data is captured on the edge that enters DRIVE so every output stays registered.
    always_comb begin
        w_enter_drive = 1'b0;
        w_rd_idx      = r_widx;
        if (bus.ADS_n) begin
            case (r_state)
                IDLE:  w_enter_drive = !bus.LRD_n && NO_WAIT;
                WAIT:  w_enter_drive = !bus.LRD_n && (r_wcnt == 3'd0);
                DRIVE: begin
                    w_enter_drive = bus.BLAST_n && NO_WAIT;
                    w_rd_idx      = r_widx + 3'd1;
                end
                default: w_enter_drive = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_word = '0;
        case (w_rd_idx)
            W_ID:    w_word = ID_WORD;
            W_RATE:  w_word = cnt_val;
            W_STAT:  w_word = pack_status(st_clk, st_enb, st_dis, st_dir, sp_brk, sp_dis, sp_dir);
            W_POS:   w_word = w_pos_rd;
            W_OVF:   w_word = {31'b0, w_ovf};
            default: w_word = '0;
        endcase
    end

    assign w_ovf_clr = w_enter_drive && (w_rd_idx == W_OVF);

    always_ff @(posedge LClk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_widx    <= '0;
            r_wcnt    <= '0;
            r_lad     <= '0;
            r_oe      <= 1'b0;
            r_ready_n <= 1'b1;
        end else begin
            r_oe      <= 1'b0;
            r_ready_n <= 1'b1;
            if (!bus.ADS_n) begin
                r_widx  <= bus.LAD_in[4:2];
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!bus.LRD_n) begin
                            r_state <= NO_WAIT ? DRIVE : WAIT;
                            r_wcnt  <= WS_LOAD;
                        end
                    end
                    WAIT: begin
                        if (bus.LRD_n) begin
                            r_state <= IDLE;
                        end else if (r_wcnt == 3'd0) begin
                            r_state <= DRIVE;
                        end else begin
                            r_wcnt <= r_wcnt - 3'd1;
                        end
                    end
                    DRIVE: begin
                        if (!bus.BLAST_n) begin
                            r_state <= TURN;
                        end else begin
                            r_widx  <= r_widx + 3'd1;
                            r_state <= NO_WAIT ? DRIVE : WAIT;
                            r_wcnt  <= WS_LOAD;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
            if (w_enter_drive) begin
                r_lad     <= w_word;
                r_oe      <= 1'b1;
                r_ready_n <= 1'b0;
            end
        end
    end

    assign bus.LAD_out = r_lad;
    assign bus.LAD_oe  = r_oe;
    assign bus.READY_n = r_ready_n;

`ifdef CNC_POS_SNAPSHOT_EN
    logic w_snap_req;
    assign w_snap_req = w_enter_drive && (w_rd_idx == W_STAT);
`endif

    cnc_step_position u_pos (
        .LClk      (LClk),
        .rst       (rst),
        .i_st_clk  (st_clk),
        .i_st_enb  (st_enb),
        .i_st_dir  (st_dir),
        .i_pos_clr (pos_clr),
        .i_ovf_clr (w_ovf_clr),
`ifdef CNC_POS_SNAPSHOT_EN
        .i_snap    (w_snap_req),
`endif
        .o_pos_rd  (w_pos_rd),
        .o_ovf     (w_ovf)
    );

endmodule

// File: tb/tb_cnc_lbus_readback.sv
// tb/tb_cnc_lbus_readback.sv - randomized bench with a transaction-level reference model for cnc_lbus_readback
module tb_cnc_lbus_readback;

    localparam int          WS = 1;
    localparam logic [31:0] ID = 32'h5C1C_0001;

    logic        LClk = 1'b0;
    logic        rst  = 1'b0;
    logic        st_clk, st_dir, st_enb, st_dis, sp_brk, sp_dis, sp_dir, pos_clr;
    logic [31:0] cnt_val;

    always #5 LClk = ~LClk;

    cnc_lbus_if bus ();

    cnc_lbus_readback #(.WAIT_STATES(WS), .ID_WORD(ID)) dut (
        .LClk(LClk), .rst(rst), .bus(bus),
        .st_clk(st_clk), .st_dir(st_dir), .st_enb(st_enb), .st_dis(st_dis),
        .sp_brk(sp_brk), .sp_dis(sp_dis), .sp_dir(sp_dir),
        .cnt_val(cnt_val), .pos_clr(pos_clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: position/overflow bookkeeping plus the word the host must see per beat.
    logic [31:0] m_pos, m_snap, exp_lad, m_word;
    logic        m_ovf, m_prev, exp_oe, exp_rdy, m_ev, plan_entry, chk_en;
    logic [2:0]  plan_idx;
    longint      m_nxt;
    logic [31:0] got_q[$];

    always @(posedge LClk) begin
        if (!rst) begin
            m_pos = 0; m_snap = 0; m_ovf = 0; m_prev = 0; exp_oe = 0; exp_rdy = 1;
        end else begin
            if (plan_entry) begin
                case (plan_idx)
                    3'd0: m_word = ID;
                    3'd1: m_word = cnt_val;
                    3'd2: m_word = {25'b0, sp_dir, sp_dis, sp_brk, st_dir, st_dis, st_enb, st_clk};
`ifdef CNC_POS_SNAPSHOT_EN
                    3'd3: m_word = m_snap;
`else
                    3'd3: m_word = m_pos;
`endif
                    3'd4: m_word = {31'b0, m_ovf};
                    default: m_word = 32'h0;
                endcase
                exp_lad = m_word; exp_oe = 1; exp_rdy = 0;
                if (plan_idx == 3'd4) m_ovf = 0;
                if (plan_idx == 3'd2) m_snap = m_pos;
            end else begin
                exp_oe = 0; exp_rdy = 1;
            end
            m_ev = 0;
            if (pos_clr) begin
                m_pos = 0;
            end else if (st_clk && !m_prev && st_enb) begin
                m_nxt = longint'($signed(m_pos)) + (st_dir ? 64'sd1 : -64'sd1);
                m_ev  = (m_nxt > 64'sd2147483647) || (m_nxt < -64'sd2147483648);
                m_pos = m_nxt[31:0];
            end
            if (m_ev) m_ovf = 1;
            m_prev = st_clk;
        end
    end

    always @(negedge LClk) begin
        if (chk_en) begin
            chk("oe", {31'b0, bus.LAD_oe}, {31'b0, exp_oe});
            chk("ready_n", {31'b0, bus.READY_n}, {31'b0, exp_rdy});
            if (exp_oe) chk("lad", bus.LAD_out, exp_lad);
            if (!bus.READY_n) got_q.push_back(bus.LAD_out);
        end
    end

    task automatic cyc();
        @(posedge LClk);
        #2;
    endtask

    // Beat k is data-valid (WS+1)*(k+1) cycles after the LRD_n-low cycle.
    task automatic rd(input logic [2:0] a, input int n);
        got_q.delete();
        bus.ADS_n = 0; bus.LRD_n = 1; bus.BLAST_n = 1;
        bus.LAD_in = ($urandom & 32'hFFFF_FFE3) | (32'(a) << 2);
        cyc();
        bus.ADS_n = 1;
        for (int t = 0; t <= n * (WS + 1); t++) begin
            plan_entry = ((t % (WS + 1)) == WS) && (t < n * (WS + 1));
            plan_idx   = a + 3'(t / (WS + 1));
            if (t == n * (WS + 1)) begin
                bus.LRD_n = 1; bus.BLAST_n = 0;
            end else begin
                bus.LRD_n   = 0;
                bus.BLAST_n = (t > 0 && (t % (WS + 1)) == 0) ? 1'b1 : 1'($urandom);
            end
            cyc();
        end
        plan_entry = 0; bus.LRD_n = 1; bus.BLAST_n = 1;
        cyc();
    endtask

    task automatic rd_pos(input string name, input logic [31:0] exp);
        rd(3'd2, 2);
        chk({name, "_beats"}, 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) chk(name, got_q[1], exp);
    endtask

    task automatic rd_one(input string name, input logic [2:0] a, input logic [31:0] exp);
        rd(a, 1);
        chk({name, "_beats"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk(name, got_q[0], exp);
    endtask

    task automatic pulse(input logic dir, input logic enb);
        st_dir = dir; st_enb = enb; st_clk = 1; cyc();
        st_clk = 0; cyc();
    endtask

    bit rnd_done;

    initial begin
        bus.ADS_n = 1; bus.LRD_n = 1; bus.BLAST_n = 1; bus.LAD_in = 0;
        {st_clk, st_dir, st_enb, st_dis, sp_brk, sp_dis, sp_dir, pos_clr} = '0;
        cnt_val = 32'h0000_1234; plan_entry = 0; plan_idx = 0; chk_en = 0; rnd_done = 0;
        repeat (3) cyc();
        chk("rst_lad", bus.LAD_out, 32'h0);
        chk("rst_oe", {31'b0, bus.LAD_oe}, 32'h0);
        chk("rst_ready", {31'b0, bus.READY_n}, 32'h1);
        rst = 1; chk_en = 1;
        cyc();

        rd_one("single_id", 3'd0, 32'h5C1C_0001);
        rd_one("rate", 3'd1, 32'h0000_1234);
        rd(3'd7, 2);
        chk("wrap_beats", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("wrap_w7", got_q[0], 32'h0);
            chk("wrap_w0", got_q[1], 32'h5C1C_0001);
        end

        pos_clr = 1; cyc(); pos_clr = 0;
        repeat (5) pulse(1, 1);
        repeat (2) pulse(0, 1);
        rd_pos("pos_3", 32'd3);
        repeat (3) pulse(1, 0);
        rd_pos("pos_hold", 32'd3);

        st_enb = 1; st_dir = 1; st_clk = 1; pos_clr = 1; cyc();
        st_clk = 0; pos_clr = 0; cyc();
        rd_pos("clr_wins", 32'd0);

        // ADS during WAIT aborts the read: no beat should appear.
        got_q.delete();
        bus.ADS_n = 0; bus.LAD_in = 32'h0; cyc();
        bus.ADS_n = 1; bus.LRD_n = 0; cyc();
        bus.ADS_n = 0; bus.LRD_n = 1; bus.LAD_in = 32'h4; cyc();
        bus.ADS_n = 1; repeat (3) cyc();
        chk("abort_beats", 32'(got_q.size()), 32'd0);

        fork
            begin
                for (int i = 0; i < 40; i++) rd(3'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    st_clk = 1'($urandom); st_dir = 1'($urandom); st_enb = 1'($urandom);
                    st_dis = 1'($urandom); sp_brk = 1'($urandom); sp_dis = 1'($urandom);
                    sp_dir = 1'($urandom); cnt_val = $urandom;
                    pos_clr = ($urandom_range(0, 15) == 0);
                    cyc();
                end
                {st_clk, st_dir, st_enb, st_dis, sp_brk, sp_dis, sp_dir, pos_clr} = '0;
            end
        join
        cyc();

        rd(3'd4, 1);
        force dut.u_pos.r_pos = 32'h7FFF_FFFF;
        m_pos = 32'h7FFF_FFFF;
        #1;
        release dut.u_pos.r_pos;
        cyc();
        pulse(1, 1);
        rd_pos("pos_wrap_up", 32'h8000_0000);
        rd_one("ovf_first", 3'd4, 32'h1);
        rd_one("ovf_second", 3'd4, 32'h0);
        pulse(0, 1);
        rd_pos("pos_wrap_dn", 32'h7FFF_FFFF);
        rd_one("ovf_dn", 3'd4, 32'h1);

        pos_clr = 1; cyc(); pos_clr = 0;
        repeat (2) pulse(1, 1);
        rd(3'd2, 1);
        repeat (4) pulse(1, 1);
`ifdef CNC_POS_SNAPSHOT_EN
        rd_one("snap_pos", 3'd3, 32'd2);
`else
        rd_one("live_pos", 3'd3, 32'd6);
`endif

        bus.ADS_n = 0; bus.LAD_in = 32'hC; cyc();
        bus.ADS_n = 1; bus.LRD_n = 0; cyc();
        rst = 0; bus.LRD_n = 1; cyc();
        rst = 1;
        chk("rst_mid_oe", {31'b0, bus.LAD_oe}, 32'h0);
        chk("rst_mid_ready", {31'b0, bus.READY_n}, 32'h1);
        cyc();
        rd_pos("rst_mid_pos", 32'd0);

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
